// File: rtl/dff_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dff_wr_arbiter
// Brief   : Round-robin arbiter that serialises NREQ requesters onto one shared
//           DFF register as write / readback-verify transactions, with a
//           sticky readback-mismatch flag.
// Revision: 1.0 - initial release
// ============================================================================
module dff_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  err_clr,
  input  logic [WIDTH-1:0]      reg_q,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  reg_we,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             found;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] pick_data;
  logic [NREQ-1:0]  win_onehot;

  // First requester at or after ptr_q, wrapping from NREQ-1 back to 0.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic [IW-1:0] idx_t;
    found = 1'b0;
    pick  = ptr_q;
    base  = 32'(ptr_q);
    idx   = 0;
    idx_t = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (base + k) % NREQ;
      idx_t = IW'(idx);
      if (!found && req[idx_t]) begin
        found = 1'b1;
        pick  = idx_t;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_onehot[i] = (win_q == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    data_d  = data_q;
    err_d   = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          data_d  = pick_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = VERIFY;
      end
      VERIFY: begin
        // A mismatch overrides a simultaneous clear.
        if (reg_q != data_q) begin
          err_d = 1'b1;
        end
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign reg_d  = data_q;
  assign reg_we = (state_q == WRITE);
  assign busy   = (state_q != IDLE);
  assign gnt    = busy ? win_onehot : '0;
  assign done   = (state_q == VERIFY) ? win_onehot : '0;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dff_wr_arbiter
// Brief   : Self-checking bench for dff_wr_arbiter against a transaction-level
//           reference model of the arbitration and verify rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dff_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  err_clr;
  logic [WIDTH-1:0]      reg_q;
  logic [WIDTH-1:0]      reg_d;
  logic                  reg_we;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  err;

  logic                  stuck = 1'b0;
  logic [WIDTH-1:0]      shadow = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: phase 0 idle, 1 writing, 2 verifying.
  int               m_phase = 0;
  int               m_ptr   = 0;
  int               m_win   = 0;
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_err   = 1'b0;

  dff_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .err_clr(err_clr),
    .reg_q(reg_q), .reg_d(reg_d), .reg_we(reg_we), .gnt(gnt),
    .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (reg_we) shadow <= reg_d;
  assign reg_q = stuck ? '0 : shadow;

  wire [14:0] obs = {reg_we, reg_d, gnt, done, busy, err};

  function automatic logic [14:0] model_vec();
    logic [3:0] oh;
    oh = 4'b0001 << m_win;
    return {(m_phase == 1), m_data, (m_phase != 0) ? oh : 4'h0,
            (m_phase == 2) ? oh : 4'h0, (m_phase != 0), m_err};
  endfunction

  // One clock: sample inputs just before the edge, advance the model, settle.
  task automatic step();
    logic [3:0]  s_req;
    logic [15:0] s_wd;
    logic        s_clr;
    logic [3:0]  s_q;
    bit          got;
    @(negedge clk); #2;
    s_req = req; s_wd = wdata; s_clr = err_clr; s_q = reg_q;
    @(posedge clk);
    if (m_phase == 0) begin
      if (s_clr) m_err = 1'b0;
      got = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!got && s_req[idx]) begin
          got = 1'b1;
          m_win = idx;
          m_data = s_wd[idx*WIDTH +: WIDTH];
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (s_clr) m_err = 1'b0;
      m_phase = 2;
    end else begin
      if (s_q != m_data) m_err = 1'b1;
      else if (s_clr) m_err = 1'b0;
      m_ptr = (m_win + 1) % NREQ;
      m_phase = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    m_phase = 0; m_ptr = 0; m_win = 0; m_data = '0; m_err = 1'b0;
    n_checks++;
    if (obs !== 15'h0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h required=%h", obs, 15'h0);
    end
    @(posedge clk); #3 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; wdata = '0; err_clr = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'h0) begin
      n_fail++; $display("FAIL reset_state: outputs=%h required=%h", obs, 15'h0);
    end
    @(posedge clk); #3 rst = 1'b1;
    step();
    n_checks++;
    if (obs !== model_vec() || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: dut=%h model=%h", obs, model_vec());
    end
  endtask

  task automatic test_single_write();
    req = 4'b0001; wdata = 16'h000A;
    step();
    n_checks++;
    if (reg_we !== 1'b1 || reg_d !== 4'hA || obs !== model_vec()) begin
      n_fail++; $display("FAIL single_write: dut=%h model=%h", obs, model_vec());
    end
    step();
    n_checks++;
    if (done !== 4'b0001 || reg_we !== 1'b0 || obs !== model_vec()) begin
      n_fail++; $display("FAIL single_done: dut=%h model=%h", obs, model_vec());
    end
    req = '0;
    step();
    n_checks++;
    if (err !== 1'b0 || obs !== model_vec()) begin
      n_fail++; $display("FAIL single_err: err=%b required=0 dut=%h", err, obs);
    end
  endtask

  task automatic test_all_req();
    logic [3:0] exp_order [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    apply_reset();
    req = 4'hF; wdata = 16'(($urandom));
    for (int s = 0; s < 15; s++) begin
      step();
      n_checks++;
      if (obs !== model_vec() || !$onehot0(gnt)) begin
        n_fail++; $display("FAIL all_req step %0d: dut=%h model=%h", s, obs, model_vec());
      end
      if (s % 3 == 0) begin
        n_checks++;
        if (gnt !== exp_order[s/3] || reg_we !== 1'b1) begin
          n_fail++;
          $display("FAIL grant_order %0d: gnt=%b required=%b", s/3, gnt, exp_order[s/3]);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    req = 4'b1000; wdata = 16'h7003;
    repeat (3) step();
    n_checks++;
    if (obs !== model_vec() || busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_setup: dut=%h model=%h", obs, model_vec());
    end
    req = 4'b1001;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || reg_d !== 4'h3 || obs !== model_vec()) begin
      n_fail++; $display("FAIL ptr_wrap: gnt=%b required=0001 dut=%h", gnt, obs);
    end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_mismatch();
    stuck = 1'b1; req = 4'b0010; wdata = 16'h0050;
    repeat (2) step();
    req = '0;
    step();
    n_checks++;
    if (err !== 1'b1 || obs !== model_vec()) begin
      n_fail++; $display("FAIL mismatch_set: err=%b required=1", err);
    end
    step();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_sticky: err=%b required=1", err);
    end
    req = 4'b0010;
    repeat (2) step();
    err_clr = 1'b1; req = '0;
    step();
    n_checks++;
    if (err !== 1'b1 || obs !== model_vec()) begin
      n_fail++; $display("FAIL set_beats_clr: err=%b required=1", err);
    end
    step();
    n_checks++;
    if (err !== 1'b0 || obs !== model_vec()) begin
      n_fail++; $display("FAIL err_clr: err=%b required=0", err);
    end
    err_clr = 1'b0; stuck = 1'b0;
  endtask

  task automatic test_reset_in_write();
    req = 4'b0010; wdata = 16'h0900;
    repeat (3) step();
    req = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || reg_we !== 1'b1 || obs !== model_vec()) begin
      n_fail++; $display("FAIL rst_write_setup: dut=%h model=%h", obs, model_vec());
    end
    apply_reset();
    step();
    n_checks++;
    if (gnt !== 4'b0100 || reg_d !== 4'h9 || obs !== model_vec()) begin
      n_fail++; $display("FAIL rst_regrant: gnt=%b required=0100 dut=%h", gnt, obs);
    end
    step();
    n_checks++;
    if (done !== 4'b0100 || obs !== model_vec()) begin
      n_fail++; $display("FAIL rst_regrant_done: done=%b required=0100", done);
    end
    req = '0;
    step();
  endtask

  task automatic test_dropped_req();
    req = 4'b0010; wdata = 16'h00C0;
    step();
    req = '0; wdata = 16'h0030;
    step();
    n_checks++;
    if (done !== 4'b0010 || reg_d !== 4'hC || obs !== model_vec()) begin
      n_fail++; $display("FAIL dropped_req: done=%b reg_d=%h required 0010/c", done, reg_d);
    end
    step();
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      req     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'(($urandom));
      wdata   = 16'(($urandom));
      err_clr = ($urandom_range(0, 7) == 0);
      stuck   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 60) == 0) apply_reset();
      step();
      n_checks++;
      if (obs !== model_vec() || !$onehot0(gnt)) begin
        n_fail++; $display("FAIL random step %0d: dut=%h model=%h", s, obs, model_vec());
      end
    end
    req = '0; err_clr = 1'b0; stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_req();
    test_ptr_wrap();
    test_mismatch();
    test_reset_in_write();
    test_dropped_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
